data_mem_ctrl: RTL and testbench

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

---
 rtl/data_mem_ctrl_if.sv | 41 ++++
 rtl/data_mem_ctrl.sv | 231 +++++++++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_ctrl_if.sv
// Bus between the load/store decoder and the data-memory controller.
// The master drives store and load requests; the slave returns the
// aligned load result, the error pulse and the clear-sweep busy flag.
interface data_mem_ctrl_if;
    logic [31:0] ram_wr_addr_i;   // byte address of the store
    logic [31:0] ram_wr_data_i;   // lane-aligned store data
    logic [3:0]  ram_wr_en_i;     // byte-lane write enables, 0 = no write
    logic        ram_rd_req_i;    // load request strobe
    logic [31:0] ram_rd_addr_i;   // byte address of the load
    logic [2:0]  load_funct3_i;   // load type
    logic [31:0] rd_data_o;       // aligned, extended load result
    logic        rd_valid_o;      // one-cycle pulse: rd_data_o valid
    logic        err_o;           // one-cycle pulse: faulting access
    logic        busy_o;          // clear sweep in progress

    modport master (
        output ram_wr_addr_i,
        output ram_wr_data_i,
        output ram_wr_en_i,
        output ram_rd_req_i,
        output ram_rd_addr_i,
        output load_funct3_i,
        input  rd_data_o,
        input  rd_valid_o,
        input  err_o,
        input  busy_o
    );

    modport slave (
        input  ram_wr_addr_i,
        input  ram_wr_data_i,
        input  ram_wr_en_i,
        input  ram_rd_req_i,
        input  ram_rd_addr_i,
        input  load_funct3_i,
        output rd_data_o,
        output rd_valid_o,
        output err_o,
        output busy_o
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// Data-memory controller: byte-lane word RAM with a post-reset clear sweep,
// one-cycle load latency, write-first forwarding for same-word read/write,
// load alignment/extension and a registered error pulse.
module data_mem_ctrl #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    data_mem_ctrl_if.slave  mem_if
);

    // Load types
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    state_t         state_q;
    logic [AW-1:0]  clr_cnt_q;
    logic           busy_q;

    // Read pipeline registers (cycle N+1 view of a cycle-N request)
    logic           rd_valid_q;
    logic           rd_err_q;
    logic           err_q;
    logic [2:0]     funct3_q;
    logic [1:0]     off_q;
    logic [3:0]     fwd_q;
    logic [31:0]    fwd_data_q;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic           run;
    logic           wr_any;
    logic           wr_oor;
    logic           wr_ok;
    logic           wr_err;
    logic [AW-1:0]  wr_word;
    logic           rd_fire;
    logic           rd_oor;
    logic           rd_bad_f3;
    logic           rd_misalign;
    logic           rd_err;
    logic [AW-1:0]  rd_word;
    logic [3:0]     fwd_d;

    // RAM write port, shared between the clear sweep and normal stores
    logic [3:0]     mem_we;
    logic [AW-1:0]  mem_waddr;
    logic [31:0]    mem_wdata;

    // Assembled word seen by the load formatter
    logic [31:0]    ram_word;
    logic [7:0]     byte_sel;
    logic [15:0]    half_sel;
    logic [31:0]    load_ext;
    logic [31:0]    rd_data_w;

    assign run     = (state_q == ST_RUN);
    assign wr_word = mem_if.ram_wr_addr_i[AW+1:2];
    assign rd_word = mem_if.ram_rd_addr_i[AW+1:2];

    // Addresses whose bits above the word index are non-zero fall outside
    // the memory; the shift keeps this valid for any AW.
    assign wr_oor  = (mem_if.ram_wr_addr_i >> (AW + 2)) != 32'd0;
    assign rd_oor  = (mem_if.ram_rd_addr_i >> (AW + 2)) != 32'd0;

    assign wr_any  = |mem_if.ram_wr_en_i;
    assign wr_ok   = run && wr_any && !wr_oor;
    assign wr_err  = run && wr_any && wr_oor;
    assign rd_fire = run && mem_if.ram_rd_req_i;

    // Classify the load: illegal funct3 and misaligned halfword/word loads
    always_comb begin
        rd_bad_f3   = 1'b0;
        rd_misalign = 1'b0;
        case (mem_if.load_funct3_i)
            F3_LB, F3_LBU: rd_misalign = 1'b0;
            F3_LH, F3_LHU: rd_misalign = mem_if.ram_rd_addr_i[0];
            F3_LW:         rd_misalign = |mem_if.ram_rd_addr_i[1:0];
            default:       rd_bad_f3   = 1'b1;
        endcase
    end

    assign rd_err = rd_fire && (rd_oor || rd_bad_f3 || rd_misalign);

    // Lanes written this cycle to the word being read are forwarded so the
    // load sees the new bytes (write-first); other lanes come from the RAM.
    assign fwd_d = (wr_ok && rd_fire && (wr_word == rd_word)) ?
                   mem_if.ram_wr_en_i : 4'b0000;

    // Write-port mux: the sweep owns the port in INIT, stores own it in RUN.
    // Nothing is written while reset is asserted.
    always_comb begin
        mem_we    = 4'b0000;
        mem_waddr = wr_word;
        mem_wdata = mem_if.ram_wr_data_i;
        if (!rst) begin
            if (!run) begin
                mem_we    = 4'b1111;
                mem_waddr = clr_cnt_q;
                mem_wdata = 32'h0;
            end else if (wr_ok) begin
                mem_we    = mem_if.ram_wr_en_i;
            end
        end
    end

    // ------------------------------------------------------------------
    // Memory: one byte-wide RAM per lane, read registered every cycle
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];
            logic [7:0] rd_byte_q;

            // Byte-lane RAM: enabled write, read-old registered read
            always_ff @(posedge clk) begin
                if (mem_we[gi]) begin
                    lane_mem[mem_waddr] <= mem_wdata[gi*8 +: 8];
                end
                rd_byte_q <= lane_mem[rd_word];
            end

            assign ram_word[gi*8 +: 8] = fwd_q[gi] ? fwd_data_q[gi*8 +: 8]
                                                   : rd_byte_q;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Clear-sweep FSM: INIT zeroes every word once, then RUN forever
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_INIT;
            clr_cnt_q <= '0;
            busy_q    <= 1'b1;
        end else begin
            case (state_q)
                ST_INIT: begin
                    clr_cnt_q <= clr_cnt_q + AW'(1);
                    if (clr_cnt_q == AW'(DEPTH - 1)) begin
                        state_q <= ST_RUN;
                        busy_q  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    busy_q <= 1'b0;
                end
                default: begin
                    state_q   <= ST_INIT;
                    clr_cnt_q <= '0;
                    busy_q    <= 1'b1;
                end
            endcase
        end
    end

    // Capture the load context for the response cycle; reset drops any
    // request sampled together with it
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
            err_q      <= 1'b0;
            funct3_q   <= 3'b000;
            off_q      <= 2'b00;
            fwd_q      <= 4'b0000;
            fwd_data_q <= 32'h0;
        end else begin
            rd_valid_q <= rd_fire;
            rd_err_q   <= rd_err;
            err_q      <= rd_err || wr_err;
            funct3_q   <= mem_if.load_funct3_i;
            off_q      <= mem_if.ram_rd_addr_i[1:0];
            fwd_q      <= fwd_d;
            fwd_data_q <= mem_if.ram_wr_data_i;
        end
    end

    // ------------------------------------------------------------------
    // Load formatter: select byte/halfword and extend. Inputs are all
    // registered, so nothing here depends on the current-cycle request.
    // ------------------------------------------------------------------
    // Byte and halfword selection by the captured offset
    always_comb begin
        byte_sel = ram_word[7:0];
        case (off_q)
            2'd0: byte_sel = ram_word[7:0];
            2'd1: byte_sel = ram_word[15:8];
            2'd2: byte_sel = ram_word[23:16];
            2'd3: byte_sel = ram_word[31:24];
            default: byte_sel = ram_word[7:0];
        endcase
        half_sel = off_q[1] ? ram_word[31:16] : ram_word[15:0];
    end

    // Sign/zero extension by load type
    always_comb begin
        load_ext = 32'h0;
        case (funct3_q)
            F3_LB:   load_ext = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  load_ext = {24'h0, byte_sel};
            F3_LH:   load_ext = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  load_ext = {16'h0, half_sel};
            F3_LW:   load_ext = ram_word;
            default: load_ext = 32'h0;
        endcase
    end

    // Faulting or absent loads present zero data
    assign rd_data_w = (rd_valid_q && !rd_err_q) ? load_ext : 32'h0;

    assign mem_if.rd_data_o  = rd_data_w;
    assign mem_if.rd_valid_o = rd_valid_q;
    assign mem_if.err_o      = err_q;
    assign mem_if.busy_o     = busy_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed testbench for data_mem_ctrl: clear sweep, load formatting,
// write-first forwarding, error responses and reset restart.
module tb_data_mem_ctrl;

    localparam int DEPTH = 1024;

    localparam logic [2:0] F_LB  = 3'b000;
    localparam logic [2:0] F_LH  = 3'b001;
    localparam logic [2:0] F_LW  = 3'b010;
    localparam logic [2:0] F_LBU = 3'b100;
    localparam logic [2:0] F_LHU = 3'b101;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    data_mem_ctrl_if mem_bus ();

    data_mem_ctrl #(.DEPTH(DEPTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .mem_if (mem_bus.slave)
    );

    always #5 clk = ~clk;

    // Load vectors against the word 32'h8081_F2F3 stored at 0x10
    logic [31:0] ext_addr [7] = '{32'h11, 32'h11, 32'h12, 32'h12, 32'h10, 32'h13, 32'h10};
    logic [2:0]  ext_f3   [7] = '{F_LB, F_LBU, F_LH, F_LHU, F_LH, F_LB, F_LW};
    logic [31:0] ext_exp  [7] = '{32'hFFFF_FFF2, 32'h0000_00F2, 32'hFFFF_8081,
                                  32'h0000_8081, 32'hFFFF_F2F3, 32'hFFFF_FF80,
                                  32'h8081_F2F3};

    // Faulting loads: misaligned, illegal funct3, out of range
    logic [31:0] err_addr [5] = '{32'h22, 32'h21, 32'h20, 32'h21, 32'(4*DEPTH)};
    logic [2:0]  err_f3   [5] = '{F_LW, F_LH, 3'b011, F_LHU, F_LW};

    // Inputs change 1 time unit after the rising edge; outputs are read there too
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        mem_bus.ram_wr_addr_i = 32'h0;
        mem_bus.ram_wr_data_i = 32'h0;
        mem_bus.ram_wr_en_i   = 4'b0000;
        mem_bus.ram_rd_req_i  = 1'b0;
        mem_bus.ram_rd_addr_i = 32'h0;
        mem_bus.load_funct3_i = 3'b000;
    endtask

    task automatic drive_wr(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] en);
        mem_bus.ram_wr_addr_i = addr;
        mem_bus.ram_wr_data_i = data;
        mem_bus.ram_wr_en_i   = en;
    endtask

    task automatic drive_rd(input logic [31:0] addr, input logic [2:0] f3);
        mem_bus.ram_rd_req_i  = 1'b1;
        mem_bus.ram_rd_addr_i = addr;
        mem_bus.load_funct3_i = f3;
    endtask

    task automatic test_reset();
        int cnt;
        rst = 1'b1;
        idle();
        tick();
        tick();
        n_checks++;
        if (mem_bus.busy_o !== 1'b1 || mem_bus.rd_valid_o !== 1'b0 ||
            mem_bus.err_o !== 1'b0 || mem_bus.rd_data_o !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: busy=%b valid=%b err=%b data=%h, required busy=1 valid=0 err=0 data=00000000",
                     mem_bus.busy_o, mem_bus.rd_valid_o, mem_bus.err_o, mem_bus.rd_data_o);
        end
        rst = 1'b0;
        cnt = 0;
        while (mem_bus.busy_o === 1'b1 && cnt < 2*DEPTH) begin
            tick();
            cnt++;
        end
        n_checks++;
        if (cnt != DEPTH) begin
            n_fail++;
            $display("FAIL busy_length: busy lasted %0d cycles, required %0d", cnt, DEPTH);
        end
        $display("reset: busy cleared after %0d cycles", cnt);
    endtask

    task automatic test_init_zero();
        logic [31:0] addr;
        for (int i = 0; i < 3; i++) begin
            addr = (i == 0) ? 32'h0 : (i == 1) ? 32'h14 : 32'(4*(DEPTH-1));
            drive_rd(addr, F_LW);
            tick();
            idle();
            n_checks++;
            if (mem_bus.rd_valid_o !== 1'b1 || mem_bus.err_o !== 1'b0 ||
                mem_bus.rd_data_o !== 32'h0) begin
                n_fail++;
                $display("FAIL init_zero[%0d]: valid=%b err=%b data=%h, required valid=1 err=0 data=00000000",
                         i, mem_bus.rd_valid_o, mem_bus.err_o, mem_bus.rd_data_o);
            end
            $display("LW %h -> %h", addr, mem_bus.rd_data_o);
        end
        tick();
        n_checks++;
        if (mem_bus.rd_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL valid_pulse: valid=%b one cycle after last load, required 0", mem_bus.rd_valid_o);
        end
    endtask

    task automatic test_load_ext();
        drive_wr(32'h10, 32'h8081_F2F3, 4'hF);
        tick();
        idle();
        $display("SW 00000010 <- 8081f2f3");
        for (int i = 0; i < 7; i++) begin
            drive_rd(ext_addr[i], ext_f3[i]);
            tick();
            idle();
            n_checks++;
            if (mem_bus.rd_valid_o !== 1'b1 || mem_bus.err_o !== 1'b0 ||
                mem_bus.rd_data_o !== ext_exp[i]) begin
                n_fail++;
                $display("FAIL load_ext[%0d]: valid=%b err=%b data=%h, required valid=1 err=0 data=%h",
                         i, mem_bus.rd_valid_o, mem_bus.err_o, mem_bus.rd_data_o, ext_exp[i]);
            end
            $display("load f3=%b addr=%h -> %h", ext_f3[i], ext_addr[i], mem_bus.rd_data_o);
            tick();
        end
    endtask

    task automatic test_back_to_back();
        drive_rd(ext_addr[0], ext_f3[0]);
        for (int i = 0; i < 7; i++) begin
            tick();
            if (i < 6) drive_rd(ext_addr[i+1], ext_f3[i+1]);
            else       idle();
            n_checks++;
            if (mem_bus.rd_valid_o !== 1'b1 || mem_bus.err_o !== 1'b0 ||
                mem_bus.rd_data_o !== ext_exp[i]) begin
                n_fail++;
                $display("FAIL back_to_back[%0d]: valid=%b err=%b data=%h, required valid=1 err=0 data=%h",
                         i, mem_bus.rd_valid_o, mem_bus.err_o, mem_bus.rd_data_o, ext_exp[i]);
            end
            $display("b2b load f3=%b addr=%h -> %h", ext_f3[i], ext_addr[i], mem_bus.rd_data_o);
        end
        tick();
    endtask

    task automatic test_write_first();
        drive_wr(32'h20, 32'h1111_1111, 4'hF);
        tick();
        // Partial-lane store and load of the same word in one cycle
        drive_wr(32'h20, 32'h0000_AB00, 4'b0010);
        drive_rd(32'h20, F_LW);
        tick();
        idle();
        n_checks++;
        if (mem_bus.rd_valid_o !== 1'b1 || mem_bus.err_o !== 1'b0 ||
            mem_bus.rd_data_o !== 32'h1111_AB11) begin
            n_fail++;
            $display("FAIL write_first: valid=%b err=%b data=%h, required valid=1 err=0 data=1111ab11",
                     mem_bus.rd_valid_o, mem_bus.err_o, mem_bus.rd_data_o);
        end
        $display("SW.lane1 00000020 + LW same cycle -> %h", mem_bus.rd_data_o);
        // Load of the just-written word alongside a store to another word
        drive_rd(32'h20, F_LW);
        drive_wr(32'h24, 32'hDEAD_BEEF, 4'hF);
        tick();
        idle();
        n_checks++;
        if (mem_bus.rd_valid_o !== 1'b1 || mem_bus.rd_data_o !== 32'h1111_AB11) begin
            n_fail++;
            $display("FAIL read_after_write: valid=%b data=%h, required valid=1 data=1111ab11",
                     mem_bus.rd_valid_o, mem_bus.rd_data_o);
        end
        $display("LW 00000020 -> %h (store to 00000024 same cycle)", mem_bus.rd_data_o);
        drive_rd(32'h24, F_LW);
        tick();
        idle();
        n_checks++;
        if (mem_bus.rd_valid_o !== 1'b1 || mem_bus.rd_data_o !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL independent_write: valid=%b data=%h, required valid=1 data=deadbeef",
                     mem_bus.rd_valid_o, mem_bus.rd_data_o);
        end
        $display("LW 00000024 -> %h", mem_bus.rd_data_o);
    endtask

    task automatic test_errors();
        for (int i = 0; i < 5; i++) begin
            drive_rd(err_addr[i], err_f3[i]);
            tick();
            idle();
            n_checks++;
            if (mem_bus.rd_valid_o !== 1'b1 || mem_bus.err_o !== 1'b1 ||
                mem_bus.rd_data_o !== 32'h0) begin
                n_fail++;
                $display("FAIL load_err[%0d]: valid=%b err=%b data=%h, required valid=1 err=1 data=00000000",
                         i, mem_bus.rd_valid_o, mem_bus.err_o, mem_bus.rd_data_o);
            end
            $display("bad load f3=%b addr=%h -> err=%b", err_f3[i], err_addr[i], mem_bus.err_o);
        end
        drive_rd(32'h20, F_LW);
        tick();
        idle();
        n_checks++;
        if (mem_bus.err_o !== 1'b0 || mem_bus.rd_data_o !== 32'h1111_AB11) begin
            n_fail++;
            $display("FAIL err_no_effect: err=%b data=%h, required err=0 data=1111ab11",
                     mem_bus.err_o, mem_bus.rd_data_o);
        end
        $display("LW 00000020 -> %h", mem_bus.rd_data_o);
    endtask

    task automatic test_wr_oor();
        drive_wr(32'(4*DEPTH), 32'hCAFE_BABE, 4'hF);
        tick();
        idle();
        n_checks++;
        if (mem_bus.err_o !== 1'b1 || mem_bus.rd_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_oor_err: err=%b valid=%b, required err=1 valid=0",
                     mem_bus.err_o, mem_bus.rd_valid_o);
        end
        $display("SW %h (out of range) -> err=%b", 32'(4*DEPTH), mem_bus.err_o);
        drive_rd(32'h0, F_LW);
        tick();
        idle();
        n_checks++;
        if (mem_bus.err_o !== 1'b0 || mem_bus.rd_data_o !== 32'h0) begin
            n_fail++;
            $display("FAIL wr_oor_word0: err=%b data=%h, required err=0 data=00000000",
                     mem_bus.err_o, mem_bus.rd_data_o);
        end
        $display("LW 00000000 -> %h", mem_bus.rd_data_o);
    endtask

    task automatic test_reset_restart();
        int cnt;
        // Load sampled together with reset produces no response
        drive_rd(32'h10, F_LW);
        rst = 1'b1;
        tick();
        idle();
        n_checks++;
        if (mem_bus.rd_valid_o !== 1'b0 || mem_bus.busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_discard: valid=%b busy=%b, required valid=0 busy=1",
                     mem_bus.rd_valid_o, mem_bus.busy_o);
        end
        rst = 1'b0;
        for (int i = 0; i < DEPTH/2; i++) tick();
        n_checks++;
        if (mem_bus.busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_sweep_busy: busy=%b, required 1", mem_bus.busy_o);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cnt = 0;
        while (mem_bus.busy_o === 1'b1 && cnt < 2*DEPTH) begin
            tick();
            cnt++;
            if (cnt == 10) begin
                drive_wr(32'h0, 32'h1234_5678, 4'hF);
                drive_rd(32'h0, F_LW);
            end else if (cnt == 11) begin
                idle();
                n_checks++;
                if (mem_bus.rd_valid_o !== 1'b0 || mem_bus.err_o !== 1'b0) begin
                    n_fail++;
                    $display("FAIL init_drop: valid=%b err=%b, required valid=0 err=0",
                             mem_bus.rd_valid_o, mem_bus.err_o);
                end
                drive_wr(32'(4*DEPTH), 32'h5555_5555, 4'hF);
            end else if (cnt == 12) begin
                idle();
            end else if (cnt == 13) begin
                n_checks++;
                if (mem_bus.err_o !== 1'b0) begin
                    n_fail++;
                    $display("FAIL init_oor_drop: err=%b, required 0", mem_bus.err_o);
                end
            end
        end
        n_checks++;
        if (cnt != DEPTH) begin
            n_fail++;
            $display("FAIL restart_busy_length: busy lasted %0d cycles, required %0d", cnt, DEPTH);
        end
        $display("restart: busy cleared after %0d cycles", cnt);
        for (int i = 0; i < 3; i++) begin
            logic [31:0] addr;
            addr = (i == 0) ? 32'h0 : (i == 1) ? 32'h10 : 32'h20;
            drive_rd(addr, F_LW);
            tick();
            idle();
            n_checks++;
            if (mem_bus.rd_valid_o !== 1'b1 || mem_bus.rd_data_o !== 32'h0) begin
                n_fail++;
                $display("FAIL restart_clear[%0d]: valid=%b data=%h, required valid=1 data=00000000",
                         i, mem_bus.rd_valid_o, mem_bus.rd_data_o);
            end
            $display("LW %h after restart -> %h", addr, mem_bus.rd_data_o);
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_init_zero();
        test_load_ext();
        test_back_to_back();
        test_write_first();
        test_errors();
        test_wr_oor();
        test_reset_restart();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Watchdog against a stuck run
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
